// File: rtl/vote_intake_if.sv
// Bus bundle for the vote intake stage: operator controls in, vote pulses,
// tallies and FSM state out.
interface vote_intake_if;
    // Event outputs are single-cycle pulses with no back-pressure: a high
    // any_valid_vote or rejected_vote means one event occurred on that cycle.
    logic       mode;
    logic       button1;
    logic       button2;
    logic       button3;
    logic       button4;
    logic       any_valid_vote;
    logic       rejected_vote;
    logic       busy;
    logic [7:0] can1_total;
    logic [7:0] can2_total;
    logic [7:0] can3_total;
    logic [7:0] can4_total;
    logic [1:0] fsm_state;

    modport master (
        output mode,
        output button1,
        output button2,
        output button3,
        output button4,
        input  any_valid_vote,
        input  rejected_vote,
        input  busy,
        input  can1_total,
        input  can2_total,
        input  can3_total,
        input  can4_total,
        input  fsm_state
    );

    modport slave (
        input  mode,
        input  button1,
        input  button2,
        input  button3,
        input  button4,
        output any_valid_vote,
        output rejected_vote,
        output busy,
        output can1_total,
        output can2_total,
        output can3_total,
        output can4_total,
        output fsm_state
    );
endinterface

// File: rtl/vote_intake.sv
// Voting front end: synchronises and debounces four candidate buttons, accepts
// one unambiguous press per vote with a post-release lockout, keeps tallies.
module vote_intake #(
    parameter int DB_CYCLES      = 4,
    parameter int LOCKOUT_CYCLES = 10
) (
    input logic         clk,
    input logic         reset,
    vote_intake_if.slave vi
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int LKW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        LOCKOUT      = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       deb_prev;
    logic [3:0]       press;
    logic [DBW-1:0]   db_cnt [4];

    logic [LKW-1:0]   lk_cnt;
    logic             lk_load;
    logic             one_hot;
    logic             vote_next;
    logic             rej_next;
    logic [3:0]       tally_inc;

    logic             vote_q;
    logic             rej_q;
    logic             busy_q;
    logic [7:0]       tally [4];

    assign raw = {vi.button4, vi.button3, vi.button2, vi.button1};

    // Two-flop synchroniser per button; the raw buttons are asynchronous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The debounced level flips only after DB_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb      <= 4'b0;
            deb_prev <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press   = deb & ~deb_prev;
    assign one_hot = (deb != 4'd0) && ((deb & (deb - 4'd1)) == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mode is only consulted in IDLE on a press cycle; other states ignore it.
    always_comb begin
        state_next = state;
        vote_next  = 1'b0;
        rej_next   = 1'b0;
        lk_load    = 1'b0;
        tally_inc  = 4'b0;
        case (state)
            IDLE: begin
                if ((press != 4'b0) && !vi.mode) begin
                    if (one_hot) begin
                        vote_next = 1'b1;
                        tally_inc = deb;
                    end else begin
                        rej_next = 1'b1;
                    end
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (deb == 4'b0) begin
                    lk_load    = 1'b1;
                    state_next = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (lk_cnt == LKW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_cnt <= '0;
        end else if (lk_load) begin
            lk_cnt <= LKW'(LOCKOUT_CYCLES);
        end else if ((state == LOCKOUT) && (lk_cnt != '0)) begin
            lk_cnt <= lk_cnt - LKW'(1);
        end
    end

    // Tallies saturate at 255; the vote pulse is still issued at saturation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                tally[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tally_inc[i] && (tally[i] != 8'hFF)) begin
                    tally[i] <= tally[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= 1'b0;
            rej_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vote_q <= vote_next;
            rej_q  <= rej_next;
            busy_q <= (state_next != IDLE);
        end
    end

    assign vi.any_valid_vote = vote_q;
    assign vi.rejected_vote  = rej_q;
    assign vi.busy           = busy_q;
    assign vi.can1_total     = tally[0];
    assign vi.can2_total     = tally[1];
    assign vi.can3_total     = tally[2];
    assign vi.can4_total     = tally[3];
    assign vi.fsm_state      = state;

endmodule

// File: tb/tb_vote_intake.sv
// Directed bench for vote_intake: a sample-window behavioural model checked
// every cycle, plus hand-computed expectations for latency, counts and tallies.
module tb_vote_intake;

    localparam int DB = 4;
    localparam int LK = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vote_intake_if vi ();

    vote_intake #(
        .DB_CYCLES      (DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vi    (vi)
    );

    always #5 clk = ~clk;

    int errors    = 0;
    int checks    = 0;
    int vote_seen = 0;
    int rej_seen  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each button keeps a window of raw samples; the debounced level
    // flips when the DB samples seen through the two-stage synchroniser all
    // disagree with it. Vote handling is tracked as "engaged until all
    // released" plus an absolute cycle number at which the lockout ends.
    bit [DB+1:0] m_hist [4];
    bit          m_d    [4];
    bit          m_rose [4];
    int          m_tally[4];
    bit          m_engaged;
    bit          m_busy;
    bit          m_vote;
    bit          m_rej;
    int          m_cyc;
    int          m_idle_at;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                m_hist[i]  = '0;
                m_d[i]     = 1'b0;
                m_rose[i]  = 1'b0;
                m_tally[i] = 0;
            end
            m_engaged = 1'b0;
            m_busy    = 1'b0;
            m_vote    = 1'b0;
            m_rej     = 1'b0;
            m_cyc     = 0;
            m_idle_at = 0;
        end else begin
            bit [3:0]    raw;
            bit [DB-1:0] window;
            int          n_held;
            int          who;
            bit          any_rose;
            raw      = {vi.button4, vi.button3, vi.button2, vi.button1};
            m_cyc    = m_cyc + 1;
            m_vote   = 1'b0;
            m_rej    = 1'b0;
            n_held   = 0;
            who      = 0;
            any_rose = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_d[i]) begin
                    n_held++;
                    who = i;
                end
                if (m_rose[i]) any_rose = 1'b1;
            end
            if (!m_busy) begin
                if (any_rose && (vi.mode == 1'b0)) begin
                    if (n_held == 1) begin
                        m_vote = 1'b1;
                        if (m_tally[who] < 255) m_tally[who] = m_tally[who] + 1;
                    end else begin
                        m_rej = 1'b1;
                    end
                    m_engaged = 1'b1;
                end
            end else if (m_engaged && (n_held == 0)) begin
                m_engaged = 1'b0;
                m_idle_at = m_cyc + LK;
            end
            m_busy = m_engaged || (m_cyc < m_idle_at);
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = {m_hist[i][DB:0], raw[i]};
                window    = m_hist[i][DB+1:2];
                m_rose[i] = 1'b0;
                if (window == {DB{~m_d[i]}}) begin
                    m_d[i]    = ~m_d[i];
                    m_rose[i] = m_d[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("any_valid_vote", int'(vi.any_valid_vote), int'(m_vote));
        check("rejected_vote",  int'(vi.rejected_vote),  int'(m_rej));
        check("busy",           int'(vi.busy),           int'(m_busy));
        check("can1_total",     int'(vi.can1_total),     m_tally[0]);
        check("can2_total",     int'(vi.can2_total),     m_tally[1]);
        check("can3_total",     int'(vi.can3_total),     m_tally[2]);
        check("can4_total",     int'(vi.can4_total),     m_tally[3]);
        if (vi.any_valid_vote) vote_seen++;
        if (vi.rejected_vote)  rej_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            1: vi.button1 = v;
            2: vi.button2 = v;
            3: vi.button3 = v;
            default: vi.button4 = v;
        endcase
    endtask

    task automatic press_release(input int idx, input int hold);
        set_btn(idx, 1'b1);
        tick(hold);
        set_btn(idx, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick(DB + 3);
        while (vi.busy && (n < 60)) begin
            tick(1);
            n++;
        end
        check("idle_reached", int'(vi.busy), 0);
        tick(2);
    endtask

    initial begin
        int lat;
        int rel;
        int base;

        vi.mode    = 1'b0;
        vi.button1 = 1'b0;
        vi.button2 = 1'b0;
        vi.button3 = 1'b0;
        vi.button4 = 1'b0;
        tick(3);
        check("reset_busy",  int'(vi.busy), 0);
        check("reset_vote",  int'(vi.any_valid_vote), 0);
        check("reset_rej",   int'(vi.rejected_vote), 0);
        check("reset_can1",  int'(vi.can1_total), 0);
        check("reset_state", int'(vi.fsm_state), 0);
        reset = 1'b1;
        tick(3);

        // Single clean vote on button2, held 20 cycles.
        set_btn(2, 1'b1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (vi.any_valid_vote && (lat < 0)) lat = k - 1;
        end
        @(negedge clk);
        set_btn(2, 1'b0);
        check("vote_latency_edges", lat, 6);
        rel = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!vi.busy && (rel < 0)) rel = k - 1;
        end
        check("busy_fall_edges", rel, 16);
        tick(2);
        check("clean_can2", int'(vi.can2_total), 1);
        check("clean_can1", int'(vi.can1_total), 0);
        check("clean_can4", int'(vi.can4_total), 0);
        check("clean_votes", vote_seen, 1);

        // Bounce then a solid hold: exactly one vote.
        set_btn(1, 1'b1); tick(1);
        set_btn(1, 1'b0); tick(1);
        set_btn(1, 1'b1); tick(11);
        set_btn(1, 1'b0);
        wait_idle();
        check("bounce_can1", int'(vi.can1_total), 1);
        check("bounce_votes", vote_seen, 2);

        // Bursts never four samples long: no vote.
        set_btn(1, 1'b1); tick(3);
        set_btn(1, 1'b0); tick(1);
        set_btn(1, 1'b1); tick(3);
        set_btn(1, 1'b0); tick(20);
        check("glitch_votes", vote_seen, 2);
        check("glitch_busy", int'(vi.busy), 0);

        // Simultaneous button1 + button3: rejected.
        set_btn(1, 1'b1);
        set_btn(3, 1'b1);
        tick(10);
        set_btn(1, 1'b0);
        set_btn(3, 1'b0);
        wait_idle();
        check("ambig_rej", rej_seen, 1);
        check("ambig_votes", vote_seen, 2);
        check("ambig_can1", int'(vi.can1_total), 1);
        check("ambig_can3", int'(vi.can3_total), 0);

        // Button4 pressed during lockout and held across return to IDLE.
        press_release(2, 10);
        tick(8);
        set_btn(4, 1'b1);
        tick(30);
        check("held_no_vote", vote_seen, 3);
        set_btn(4, 1'b0);
        tick(20);
        check("held_release_no_vote", vote_seen, 3);
        check("held_can4", int'(vi.can4_total), 0);
        press_release(4, 10);
        wait_idle();
        check("repress_can4", int'(vi.can4_total), 1);
        check("repress_can2", int'(vi.can2_total), 2);
        check("repress_votes", vote_seen, 4);

        // Result mode: presses ignored.
        vi.mode = 1'b1;
        for (int n = 0; n < 5; n++) begin
            press_release(1, 8);
            tick(8);
        end
        tick(4);
        vi.mode = 1'b0;
        check("mode1_votes", vote_seen, 4);
        check("mode1_rej", rej_seen, 1);
        check("mode1_can1", int'(vi.can1_total), 1);

        // Saturation: 260 separated presses on top of the existing one.
        base = vote_seen;
        for (int n = 1; n <= 260; n++) begin
            press_release(1, 8);
            wait_idle();
            if (n == 250) check("sat_mid_can1", int'(vi.can1_total), 251);
        end
        check("sat_pulses", vote_seen - base, 260);
        check("sat_can1", int'(vi.can1_total), 255);

        // Async reset while waiting for release with can3 at 7.
        for (int n = 0; n < 6; n++) begin
            press_release(3, 8);
            wait_idle();
        end
        set_btn(3, 1'b1);
        tick(10);
        check("pre_reset_can3", int'(vi.can3_total), 7);
        check("pre_reset_state", int'(vi.fsm_state), 1);
        check("pre_reset_busy", int'(vi.busy), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_busy",  int'(vi.busy), 0);
        check("rst_vote",  int'(vi.any_valid_vote), 0);
        check("rst_rej",   int'(vi.rejected_vote), 0);
        check("rst_state", int'(vi.fsm_state), 0);
        check("rst_can1",  int'(vi.can1_total), 0);
        check("rst_can2",  int'(vi.can2_total), 0);
        check("rst_can3",  int'(vi.can3_total), 0);
        check("rst_can4",  int'(vi.can4_total), 0);
        set_btn(3, 1'b0);
        tick(3);
        reset = 1'b1;
        tick(3);
        press_release(3, 10);
        wait_idle();
        check("post_reset_can3", int'(vi.can3_total), 1);
        check("post_reset_can1", int'(vi.can1_total), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
